// File: rtl/voter_pkg.sv
// Shared types and verdict encodings for the voter_tally block.
package voter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_e;

  localparam logic [2:0] RES_REJECT = 3'b100;
  localparam logic [2:0] RES_TIE    = 3'b010;
  localparam logic [2:0] RES_PASS   = 3'b001;
  localparam logic [2:0] RES_NONE   = 3'b000;

endpackage

// File: rtl/voter_tally_if.sv
// Host/voter-facing signal bundle of voter_tally; slave modport is the block side.
interface voter_tally_if #(
  parameter int unsigned N_VOTERS = 4
);
  localparam int unsigned ID_W  = ($clog2(N_VOTERS) > 1) ? $clog2(N_VOTERS) : 1;
  localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);

  logic             start;
  logic             vote_valid;
  logic [ID_W-1:0]  vote_id;
  logic             vote_yes;
  logic             result_ack;
  logic             busy;
  logic             result_valid;
  logic [3:1]       O;
  logic [CNT_W-1:0] yes_cnt;
  logic [CNT_W-1:0] no_cnt;
  logic             dup_err;

  modport master (
    output start, vote_valid, vote_id, vote_yes, result_ack,
    input  busy, result_valid, O, yes_cnt, no_cnt, dup_err
  );

  modport slave (
    input  start, vote_valid, vote_id, vote_yes, result_ack,
    output busy, result_valid, O, yes_cnt, no_cnt, dup_err
  );

endinterface

// File: rtl/voter_timeout_cnt.sv
// COLLECT-state cycle counter; o_expired marks the LIMIT-th cycle since clear.
module voter_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAXV = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // r_cnt counts completed COLLECT cycles, so LAST is the LIMIT-th one in progress.
  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/voter_tally.sv
// N-voter ballot collector with one-hot verdict; VOTER_TIMEOUT_EN adds a COLLECT timeout.
module voter_tally
  import voter_pkg::*;
#(
  parameter int unsigned N_VOTERS    = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  voter_tally_if.slave bus
);
  localparam int unsigned ID_W  = ($clog2(N_VOTERS) > 1) ? $clog2(N_VOTERS) : 1;
  localparam int unsigned CNT_W = $clog2(N_VOTERS + 1);
  localparam logic [CNT_W:0] N_FULL = (CNT_W + 1)'(N_VOTERS);

  state_e              r_state;
  logic [N_VOTERS-1:0] r_voted;
  logic [CNT_W-1:0]    r_yes;
  logic [CNT_W-1:0]    r_no;
  logic                r_busy;
  logic                r_rv;
  logic [2:0]          r_o;
  logic                r_dup;

  logic [ID_W-1:0]  w_id;
  logic             w_in_range;
  logic             w_accept;
  logic [CNT_W-1:0] w_yes_nxt;
  logic [CNT_W-1:0] w_no_nxt;
  logic [CNT_W:0]   w_total;
  logic             w_full;
  logic             w_timeout;
  logic             w_close;
  logic [2:0]       w_verdict;

  assign w_id       = bus.vote_id;
  assign w_in_range = (32'(w_id) < N_VOTERS);

  always_comb begin
    w_accept  = 1'b0;
    w_yes_nxt = r_yes;
    w_no_nxt  = r_no;
    if ((r_state == ST_COLLECT) && bus.vote_valid && w_in_range) begin
      w_accept = !r_voted[w_id];
    end
    if (w_accept) begin
      if (bus.vote_yes) begin
        w_yes_nxt = r_yes + CNT_W'(1);
      end else begin
        w_no_nxt = r_no + CNT_W'(1);
      end
    end
    w_total = {1'b0, w_yes_nxt} + {1'b0, w_no_nxt};
    w_full  = w_accept && (w_total == N_FULL);
    w_close = (r_state == ST_COLLECT) && (w_full || w_timeout);
    // Verdict uses post-ballot tallies so a same-cycle ballot counts before a timeout.
    if (w_yes_nxt > w_no_nxt) begin
      w_verdict = RES_PASS;
    end else if (w_yes_nxt == w_no_nxt) begin
      w_verdict = RES_TIE;
    end else begin
      w_verdict = RES_REJECT;
    end
  end

`ifdef VOTER_TIMEOUT_EN
  logic w_tmo_clear;
  logic w_tmo_en;

  assign w_tmo_clear = (r_state == ST_IDLE) && bus.start;
  assign w_tmo_en    = (r_state == ST_COLLECT);

  voter_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmo_clear),
    .i_en     (w_tmo_en),
    .o_expired(w_timeout)
  );
`else
  // No counter in this build; TIMEOUT_CYC only keeps the parameter list uniform.
  assign w_timeout = 1'b0 && (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_voted <= '0;
      r_yes   <= '0;
      r_no    <= '0;
      r_busy  <= 1'b0;
      r_rv    <= 1'b0;
      r_o     <= RES_NONE;
      r_dup   <= 1'b0;
    end else begin
      r_dup <= (r_state == ST_COLLECT) && bus.vote_valid && !w_accept;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b1;
            r_voted <= '0;
            r_yes   <= '0;
            r_no    <= '0;
          end
        end
        ST_COLLECT: begin
          r_yes <= w_yes_nxt;
          r_no  <= w_no_nxt;
          if (w_accept) begin
            r_voted[w_id] <= 1'b1;
          end
          if (w_close) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_rv    <= 1'b1;
            r_o     <= w_verdict;
          end
        end
        ST_DONE: begin
          if (bus.result_ack) begin
            r_state <= ST_IDLE;
            r_rv    <= 1'b0;
            r_o     <= RES_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.result_valid = r_rv;
  assign bus.O            = r_o;
  assign bus.yes_cnt      = r_yes;
  assign bus.no_cnt       = r_no;
  assign bus.dup_err      = r_dup;

endmodule

// File: tb/tb_voter_tally.sv
// Scoreboard bench for voter_tally (N=4 main instance, N=6 for out-of-range ids).
module tb_voter_tally;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  voter_tally_if #(.N_VOTERS(4)) if4 ();
  voter_tally_if #(.N_VOTERS(6)) if6 ();

  voter_tally #(.N_VOTERS(4), .TIMEOUT_CYC(16)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  voter_tally #(.N_VOTERS(6), .TIMEOUT_CYC(64)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));

  typedef struct {
    int o;
    int yes;
    int no;
    int cyc;
  } exp_t;

  exp_t res4_q[$];
  exp_t res6_q[$];
  exp_t dup4_q[$];
  exp_t dup6_q[$];

  int checks = 0;
  int errors = 0;

  int         m_yes[2];
  int         m_no[2];
  logic [7:0] m_voted[2];
  int         m_exp_o[2];
  int         nv[2] = '{4, 6};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e, input int o, input int y, input int n);
    check({tag, "_O"}, o, e.o);
    check({tag, "_yes"}, y, e.yes);
    check({tag, "_no"}, n, e.no);
    check({tag, "_cycle"}, cyc, e.cyc);
  endtask

  // Monitors: pop an expectation whenever a DUT raises a verdict or a dup_err pulse.
  logic rv4_prev = 1'b0;
  logic rv6_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if4.result_valid && !rv4_prev) begin
      check("res4_expected", int'(res4_q.size() != 0), 1);
      if (res4_q.size() != 0) begin
        e = res4_q.pop_front();
        cmp_out("res4", e, int'(if4.O), int'(if4.yes_cnt), int'(if4.no_cnt));
      end
    end
    if (if4.dup_err) begin
      check("dup4_expected", int'(dup4_q.size() != 0), 1);
      if (dup4_q.size() != 0) begin
        e = dup4_q.pop_front();
        cmp_out("dup4", e, int'(if4.O), int'(if4.yes_cnt), int'(if4.no_cnt));
      end
    end
    if (if6.result_valid && !rv6_prev) begin
      check("res6_expected", int'(res6_q.size() != 0), 1);
      if (res6_q.size() != 0) begin
        e = res6_q.pop_front();
        cmp_out("res6", e, int'(if6.O), int'(if6.yes_cnt), int'(if6.no_cnt));
      end
    end
    if (if6.dup_err) begin
      check("dup6_expected", int'(dup6_q.size() != 0), 1);
      if (dup6_q.size() != 0) begin
        e = dup6_q.pop_front();
        cmp_out("dup6", e, int'(if6.O), int'(if6.yes_cnt), int'(if6.no_cnt));
      end
    end
    rv4_prev <= if4.result_valid;
    rv6_prev <= if6.result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int inst, input int exp_o);
    m_yes[inst]   = 0;
    m_no[inst]    = 0;
    m_voted[inst] = '0;
    m_exp_o[inst] = exp_o;
    if (inst == 0) if4.start = 1'b1;
    else           if6.start = 1'b1;
    tick();
    if4.start = 1'b0;
    if6.start = 1'b0;
    if (inst == 0) begin
      check("start4_busy", int'(if4.busy), 1);
      check("start4_tally", int'(if4.yes_cnt) + int'(if4.no_cnt), 0);
    end else begin
      check("start6_busy", int'(if6.busy), 1);
      check("start6_tally", int'(if6.yes_cnt) + int'(if6.no_cnt), 0);
    end
  endtask

  task automatic ballot(input int inst, input logic [2:0] id, input logic y);
    exp_t e;
    logic acc;
    acc = (int'(id) < nv[inst]) && !m_voted[inst][id];
    e.cyc = cyc + 1;
    if (acc) begin
      m_voted[inst][id] = 1'b1;
      if (y) m_yes[inst]++;
      else   m_no[inst]++;
    end
    e.yes = m_yes[inst];
    e.no  = m_no[inst];
    if (!acc) begin
      e.o = 0;
      if (inst == 0) dup4_q.push_back(e);
      else           dup6_q.push_back(e);
    end else if (m_yes[inst] + m_no[inst] == nv[inst]) begin
      e.o = m_exp_o[inst];
      if (inst == 0) res4_q.push_back(e);
      else           res6_q.push_back(e);
    end
    if (inst == 0) begin
      if4.vote_valid = 1'b1;
      if4.vote_id    = id[1:0];
      if4.vote_yes   = y;
    end else begin
      if6.vote_valid = 1'b1;
      if6.vote_id    = id;
      if6.vote_yes   = y;
    end
    tick();
    if4.vote_valid = 1'b0;
    if6.vote_valid = 1'b0;
    if (inst == 0) begin
      check("tally4_yes", int'(if4.yes_cnt), m_yes[0]);
      check("tally4_no", int'(if4.no_cnt), m_no[0]);
    end else begin
      check("tally6_yes", int'(if6.yes_cnt), m_yes[1]);
      check("tally6_no", int'(if6.no_cnt), m_no[1]);
    end
  endtask

  task automatic do_ack(input int inst);
    if (inst == 0) if4.result_ack = 1'b1;
    else           if6.result_ack = 1'b1;
    tick();
    if4.result_ack = 1'b0;
    if6.result_ack = 1'b0;
    if (inst == 0) begin
      check("ack4_rv", int'(if4.result_valid), 0);
      check("ack4_O", int'(if4.O), 0);
    end else begin
      check("ack6_rv", int'(if6.result_valid), 0);
      check("ack6_O", int'(if6.O), 0);
    end
  endtask

  logic [2:0] ids6[8]  = '{3'd7, 3'd0, 3'd1, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5};
  logic       yes6[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int   b;
    exp_t te;
    rst = 1'b1;
    {if4.start, if4.vote_valid, if4.vote_id, if4.vote_yes, if4.result_ack} = '0;
    {if6.start, if6.vote_valid, if6.vote_id, if6.vote_yes, if6.result_ack} = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", int'(if4.busy), 0);
    check("rst_rv", int'(if4.result_valid), 0);
    check("rst_dup", int'(if4.dup_err), 0);
    check("rst_O", int'(if4.O), 0);
    check("rst_yes", int'(if4.yes_cnt), 0);
    check("rst_no", int'(if4.no_cnt), 0);

    // Unanimous no.
    do_start(0, 3'b100);
    for (int i = 0; i < 4; i++) ballot(0, 3'(i), 1'b0);
    do_ack(0);

    // Tie, then start/vote_valid while DONE must be ignored.
    do_start(0, 3'b010);
    ballot(0, 3'd0, 1'b1);
    ballot(0, 3'd1, 1'b1);
    ballot(0, 3'd2, 1'b0);
    ballot(0, 3'd3, 1'b0);
    if4.start      = 1'b1;
    if4.vote_valid = 1'b1;
    if4.vote_id    = 2'd0;
    if4.vote_yes   = 1'b1;
    tick();
    if4.start      = 1'b0;
    if4.vote_valid = 1'b0;
    check("done_hold_rv", int'(if4.result_valid), 1);
    check("done_hold_busy", int'(if4.busy), 0);
    check("done_hold_O", int'(if4.O), 2);
    check("done_hold_yes", int'(if4.yes_cnt), 2);
    check("done_hold_no", int'(if4.no_cnt), 2);
    do_ack(0);

    // Pass.
    do_start(0, 3'b001);
    ballot(0, 3'd0, 1'b1);
    ballot(0, 3'd1, 1'b1);
    ballot(0, 3'd2, 1'b1);
    ballot(0, 3'd3, 1'b0);
    do_ack(0);

    // Duplicate ballot is rejected; yes=1 (id2), no=3 -> reject.
    do_start(0, 3'b100);
    ballot(0, 3'd2, 1'b1);
    ballot(0, 3'd2, 1'b0);
    ballot(0, 3'd0, 1'b0);
    ballot(0, 3'd1, 1'b0);
    check("bad_still_busy", int'(if4.busy), 1);
    ballot(0, 3'd3, 1'b0);
    do_ack(0);

    // Out-of-range ids 7 and 6 on N=6; yes ids 0,1,2,5 vs no 3,4 -> pass.
    do_start(1, 3'b001);
    for (int i = 0; i < 8; i++) ballot(1, ids6[i], yes6[i]);
    do_ack(1);

    // Reset mid-COLLECT abandons the session.
    do_start(0, 3'b000);
    ballot(0, 3'd0, 1'b1);
    ballot(0, 3'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(if4.busy), 0);
    check("midrst_rv", int'(if4.result_valid), 0);
    check("midrst_dup", int'(if4.dup_err), 0);
    check("midrst_O", int'(if4.O), 0);
    check("midrst_yes", int'(if4.yes_cnt), 0);
    check("midrst_no", int'(if4.no_cnt), 0);
    do_start(0, 3'b010);
    ballot(0, 3'd0, 1'b1);
    ballot(0, 3'd1, 1'b0);
    ballot(0, 3'd2, 1'b1);
    ballot(0, 3'd3, 1'b0);
    do_ack(0);

`ifdef VOTER_TIMEOUT_EN
    // Timeout with one yes: DONE 16 cycles after busy rises.
    do_start(0, 3'b000);
    b = cyc;
    te = '{o: 1, yes: 1, no: 0, cyc: b + 16};
    res4_q.push_back(te);
    ballot(0, 3'd1, 1'b1);
    while (cyc < b + 16) tick();
    do_ack(0);

    // A no ballot on the expiry cycle is counted before the verdict.
    do_start(0, 3'b000);
    b = cyc;
    ballot(0, 3'd1, 1'b1);
    while (cyc < b + 15) tick();
    te = '{o: 2, yes: 1, no: 1, cyc: b + 16};
    res4_q.push_back(te);
    ballot(0, 3'd2, 1'b0);
    do_ack(0);
`endif

    repeat (3) tick();
    check("res4_drained", res4_q.size(), 0);
    check("res6_drained", res6_q.size(), 0);
    check("dup4_drained", dup4_q.size(), 0);
    check("dup6_drained", dup6_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
